// File: rtl/guess_checker_pkg.sv
// Shared definitions for the Mastermind-style guess checker.
// Holds the evaluation state encoding, slot count, per-phase cycle counts
// and the default colour-code width used by guess_checker and its tracker.
package guess_checker_pkg;

   localparam int DEFAULT_COLOR_W = 3;
   localparam int SLOTS           = 4;
   localparam int EXACT_CYCLES    = 4;
   localparam int COLOR_CYCLES    = 16;

   typedef logic [DEFAULT_COLOR_W-1:0] color_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      EXACT = 2'd1,
      COLOR = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/guess_attempt_tracker.sv
// Per-game bookkeeping for the guess checker.
// Counts scored guesses, remembers whether the last result was a win and
// raises game_over on a win or once the attempt budget is used up.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   done         strobe: a result is being committed this cycle
//   exact_cnt    exact-position count of the result being committed
//   new_game     clears all game state
//   win          last committed result had four exact matches
//   game_over    win, or attempts reached MAX_GUESSES
//   attempts     scored guesses this game, saturating at MAX_GUESSES
module guess_attempt_tracker #(
   parameter int MAX_GUESSES = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               done,
   input  logic [2:0]                         exact_cnt,
   input  logic                               new_game,
   output logic                               win,
   output logic                               game_over,
   output logic [$clog2(MAX_GUESSES+1)-1:0]   attempts
);

   localparam int ATT_W = $clog2(MAX_GUESSES + 1);
   localparam logic [ATT_W-1:0] MAX_ATT = ATT_W'(MAX_GUESSES);

   logic [ATT_W-1:0] attemptsNext;
   logic             winNext;

   // The attempt counter holds at the budget rather than wrapping, and the
   // win flag is derived from the result being committed right now so that
   // game_over reflects this very guess in the same cycle done rises.
   always_comb begin
      attemptsNext = (attempts == MAX_ATT) ? attempts : attempts + {{(ATT_W-1){1'b0}}, 1'b1};
      winNext      = (exact_cnt == 3'd4);
   end

   // A new game wipes everything; otherwise state only moves when a result
   // is committed, so the display sees stable values between guesses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         attempts  <= '0;
         win       <= 1'b0;
         game_over <= 1'b0;
      end else if (new_game) begin
         attempts  <= '0;
         win       <= 1'b0;
         game_over <= 1'b0;
      end else if (done) begin
         attempts  <= attemptsNext;
         win       <= winNext;
         game_over <= winNext || (attemptsNext == MAX_ATT);
      end
   end

endmodule

// File: rtl/guess_checker.sv
// Scores a 4-slot colour guess against a latched secret, Mastermind style.
// An EXACT phase walks the four slots marking positional matches, then a
// COLOR phase walks every (guess slot, secret slot) pair counting colour
// matches among slots not already consumed, so duplicates count once.
// Optional feature macro: GUESS_CHECKER_EARLY_EXIT_EN -- when defined, a
// guess with four exact matches skips the COLOR phase (results unchanged,
// only latency shortens).
// Ports:
//   clk, rst                     system clock, asynchronous active-high reset
//   new_game                     latch secret_zero..three, clear game state
//   secret_zero..secret_three    secret slot codes
//   start                        commit guess_zero..guess_three for scoring
//   guess_zero..guess_three      guess slot codes
//   busy                         evaluation in progress
//   done                         one-cycle pulse, result valid
//   exact_cnt, color_cnt         last result's exact / misplaced counts
//   win, game_over, attempts     game status from guess_attempt_tracker
module guess_checker
   import guess_checker_pkg::*;
#(
   parameter int COLOR_W     = DEFAULT_COLOR_W,
   parameter int MAX_GUESSES = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               new_game,
   input  logic [COLOR_W-1:0]                 secret_zero,
   input  logic [COLOR_W-1:0]                 secret_one,
   input  logic [COLOR_W-1:0]                 secret_two,
   input  logic [COLOR_W-1:0]                 secret_three,
   input  logic                               start,
   input  logic [COLOR_W-1:0]                 guess_zero,
   input  logic [COLOR_W-1:0]                 guess_one,
   input  logic [COLOR_W-1:0]                 guess_two,
   input  logic [COLOR_W-1:0]                 guess_three,
   output logic                               busy,
   output logic                               done,
   output logic [2:0]                         exact_cnt,
   output logic [2:0]                         color_cnt,
   output logic                               win,
   output logic                               game_over,
   output logic [$clog2(MAX_GUESSES+1)-1:0]   attempts
);

   localparam logic [3:0] EXACT_LAST = 4'(EXACT_CYCLES - 1);
   localparam logic [3:0] COLOR_LAST = 4'(COLOR_CYCLES - 1);

   state_t             state;
   state_t             nextState;
   logic [COLOR_W-1:0] secretReg [SLOTS];
   logic [COLOR_W-1:0] guessReg  [SLOTS];
   logic [SLOTS-1:0]   exactFlags;
   logic [SLOTS-1:0]   guessUsed;
   logic [SLOTS-1:0]   secretUsed;
   logic [2:0]         exactCount;
   logic [2:0]         exactCountNext;
   logic [2:0]         colorCount;
   logic [3:0]         stepCnt;
   logic [1:0]         outerIdx;
   logic [1:0]         innerIdx;
   logic               exactHit;
   logic               colorHit;
   logic               exactLast;
   logic               colorLast;
   logic               startAccept;
   logic               commitResult;
   logic               doneReg;

   // One step counter serves both phases: its low bits are the slot index
   // during EXACT, and during COLOR the high bits pick the guess slot while
   // the low bits sweep the secret slots. A colour hit is only allowed on
   // slots that neither matched exactly nor were already paired.
   always_comb begin
      outerIdx       = stepCnt[3:2];
      innerIdx       = stepCnt[1:0];
      exactHit       = (guessReg[innerIdx] == secretReg[innerIdx]);
      colorHit       = !exactFlags[outerIdx] && !guessUsed[outerIdx] &&
                       !exactFlags[innerIdx] && !secretUsed[innerIdx] &&
                       (guessReg[outerIdx] == secretReg[innerIdx]);
      exactCountNext = exactHit ? exactCount + 3'd1 : exactCount;
      exactLast      = (stepCnt == EXACT_LAST);
      colorLast      = (stepCnt == COLOR_LAST);
      startAccept    = (state == IDLE) && start && !game_over && !new_game;
      commitResult   = (state == DONE) && !new_game;
   end

   // State register for the evaluation sequencer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic. new_game aborts from anywhere; otherwise the phases
   // run for a fixed number of steps, with the optional shortcut to DONE
   // when all four slots matched exactly.
   always_comb begin
      nextState = state;
      if (new_game) begin
         nextState = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (startAccept) begin
                  nextState = EXACT;
               end
            end
            EXACT: begin
               if (exactLast) begin
`ifdef GUESS_CHECKER_EARLY_EXIT_EN
                  nextState = (exactCountNext == 3'd4) ? DONE : COLOR;
`else
                  nextState = COLOR;
`endif
               end
            end
            COLOR: begin
               if (colorLast) begin
                  nextState = DONE;
               end
            end
            DONE: begin
               nextState = IDLE;
            end
            default: begin
               nextState = IDLE;
            end
         endcase
      end
   end

   // Datapath: snapshot the guess on acceptance so later input changes are
   // harmless, accumulate counts during the phases, and publish the result
   // together with the done pulse on the DONE cycle. Published counts hold
   // until the next result, a new game or reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < SLOTS; k++) begin
            secretReg[k] <= '0;
            guessReg[k]  <= '0;
         end
         exactFlags <= '0;
         guessUsed  <= '0;
         secretUsed <= '0;
         exactCount <= '0;
         colorCount <= '0;
         stepCnt    <= '0;
         exact_cnt  <= '0;
         color_cnt  <= '0;
         doneReg    <= 1'b0;
      end else begin
         doneReg <= 1'b0;
         if (new_game) begin
            secretReg[0] <= secret_zero;
            secretReg[1] <= secret_one;
            secretReg[2] <= secret_two;
            secretReg[3] <= secret_three;
            exact_cnt    <= '0;
            color_cnt    <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (startAccept) begin
                     guessReg[0] <= guess_zero;
                     guessReg[1] <= guess_one;
                     guessReg[2] <= guess_two;
                     guessReg[3] <= guess_three;
                     exactFlags  <= '0;
                     guessUsed   <= '0;
                     secretUsed  <= '0;
                     exactCount  <= '0;
                     colorCount  <= '0;
                     stepCnt     <= '0;
                  end
               end
               EXACT: begin
                  if (exactHit) begin
                     exactFlags[innerIdx] <= 1'b1;
                  end
                  exactCount <= exactCountNext;
                  stepCnt    <= exactLast ? 4'd0 : stepCnt + 4'd1;
               end
               COLOR: begin
                  if (colorHit) begin
                     guessUsed[outerIdx]  <= 1'b1;
                     secretUsed[innerIdx] <= 1'b1;
                     colorCount           <= colorCount + 3'd1;
                  end
                  stepCnt <= stepCnt + 4'd1;
               end
               DONE: begin
                  doneReg   <= 1'b1;
                  exact_cnt <= exactCount;
                  color_cnt <= colorCount;
               end
               default: begin
                  doneReg <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = doneReg;

   guess_attempt_tracker #(
      .MAX_GUESSES (MAX_GUESSES)
   ) attemptTracker (
      .clk       (clk),
      .rst       (rst),
      .done      (commitResult),
      .exact_cnt (exactCount),
      .new_game  (new_game),
      .win       (win),
      .game_over (game_over),
      .attempts  (attempts)
   );

endmodule

// File: tb/tb_guess_checker.sv
// Directed testbench for guess_checker: hand-computed Mastermind scores,
// latency, duplicate handling, attempt exhaustion, ignored starts and
// aborts by new_game and by reset. Honours GUESS_CHECKER_EARLY_EXIT_EN.
module tb_guess_checker;

   localparam int FULL_LAT = 21;
`ifdef GUESS_CHECKER_EARLY_EXIT_EN
   localparam int WIN_LAT = 5;
`else
   localparam int WIN_LAT = 21;
`endif

   logic       clk;
   logic       rst;
   logic       new_game;
   logic [2:0] secret_zero, secret_one, secret_two, secret_three;
   logic       start;
   logic [2:0] guess_zero, guess_one, guess_two, guess_three;
   logic       busy;
   logic       done;
   logic [2:0] exact_cnt;
   logic [2:0] color_cnt;
   logic       win;
   logic       game_over;
   logic [3:0] attempts;

   int checkCount = 0;
   int errorCount = 0;

   guess_checker #(
      .COLOR_W     (3),
      .MAX_GUESSES (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .new_game     (new_game),
      .secret_zero  (secret_zero),
      .secret_one   (secret_one),
      .secret_two   (secret_two),
      .secret_three (secret_three),
      .start        (start),
      .guess_zero   (guess_zero),
      .guess_one    (guess_one),
      .guess_two    (guess_two),
      .guess_three  (guess_three),
      .busy         (busy),
      .done         (done),
      .exact_cnt    (exact_cnt),
      .color_cnt    (color_cnt),
      .win          (win),
      .game_over    (game_over),
      .attempts     (attempts)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic newGame(input int s0, input int s1, input int s2, input int s3);
      secret_zero  = 3'(s0);
      secret_one   = 3'(s1);
      secret_two   = 3'(s2);
      secret_three = 3'(s3);
      new_game = 1'b1;
      tick();
      new_game = 1'b0;
   endtask

   // Present a guess and pulse start for one clock edge.
   task automatic applyStimulus(input int g0, input int g1, input int g2, input int g3);
      guess_zero  = 3'(g0);
      guess_one   = 3'(g1);
      guess_two   = 3'(g2);
      guess_three = 3'(g3);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic waitForDone(output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 100) begin
         tick();
         cycles++;
      end
   endtask

   // Counts done pulses over a window; used where no result may appear.
   task automatic expectNoDone(input string tag, input int window);
      int pulses;
      pulses = 0;
      for (int k = 0; k < window; k++) begin
         tick();
         if (done === 1'b1) pulses++;
      end
      checkOutput(tag, pulses, 0);
   endtask

   task automatic scoreGuess(input string tag,
                             input int g0, input int g1, input int g2, input int g3,
                             input int expLat, input int expExact, input int expColor,
                             input int expWin, input int expOver, input int expAtt);
      int cycles;
      applyStimulus(g0, g1, g2, g3);
      checkOutput({tag, "_busy"}, int'(busy), 1);
      waitForDone(cycles);
      checkOutput({tag, "_latency"}, cycles, expLat);
      checkOutput({tag, "_exact"}, int'(exact_cnt), expExact);
      checkOutput({tag, "_color"}, int'(color_cnt), expColor);
      checkOutput({tag, "_win"}, int'(win), expWin);
      checkOutput({tag, "_over"}, int'(game_over), expOver);
      checkOutput({tag, "_attempts"}, int'(attempts), expAtt);
      tick();
      checkOutput({tag, "_donepulse"}, int'(done), 0);
   endtask

   initial begin
      int cycles;
      rst = 1'b1;
      new_game = 1'b0;
      start = 1'b0;
      {secret_zero, secret_one, secret_two, secret_three} = '0;
      {guess_zero, guess_one, guess_two, guess_three} = '0;
      tick();
      tick();
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_exact", int'(exact_cnt), 0);
      checkOutput("reset_color", int'(color_cnt), 0);
      checkOutput("reset_win", int'(win), 0);
      checkOutput("reset_over", int'(game_over), 0);
      checkOutput("reset_attempts", int'(attempts), 0);
      rst = 1'b0;
      tick();

      $display("[TB] exact win");
      newGame(1, 2, 3, 4);
      scoreGuess("win", 1, 2, 3, 4, WIN_LAT, 4, 0, 1, 1, 1);
      applyStimulus(4, 3, 2, 1);
      checkOutput("win_locked_busy", int'(busy), 0);

      $display("[TB] all misplaced");
      newGame(1, 2, 3, 4);
      checkOutput("newgame_clear_exact", int'(exact_cnt), 0);
      checkOutput("newgame_clear_over", int'(game_over), 0);
      scoreGuess("misplaced", 4, 3, 2, 1, FULL_LAT, 0, 4, 0, 0, 1);

      $display("[TB] duplicate colours");
      newGame(1, 1, 2, 2);
      scoreGuess("dup", 1, 2, 1, 5, FULL_LAT, 1, 2, 0, 0, 1);

      $display("[TB] start ignored while busy");
      newGame(1, 2, 3, 4);
      applyStimulus(4, 3, 2, 1);
      tick();
      tick();
      tick();
      applyStimulus(1, 2, 3, 4);
      waitForDone(cycles);
      checkOutput("busy_ign_latency", cycles, FULL_LAT - 4);
      checkOutput("busy_ign_exact", int'(exact_cnt), 0);
      checkOutput("busy_ign_color", int'(color_cnt), 4);
      checkOutput("busy_ign_attempts", int'(attempts), 1);
      expectNoDone("busy_ign_second_done", 30);
      checkOutput("busy_ign_attempts_after", int'(attempts), 1);

      $display("[TB] exhaustion");
      newGame(1, 2, 3, 4);
      for (int k = 0; k < 8; k++) begin
         scoreGuess($sformatf("lose%0d", k), 7, 7, 7, 7, FULL_LAT, 0, 0, 0,
                    (k == 7) ? 1 : 0, k + 1);
      end
      applyStimulus(1, 2, 3, 4);
      checkOutput("exhaust_ninth_busy", int'(busy), 0);
      expectNoDone("exhaust_ninth_done", 30);
      checkOutput("exhaust_ninth_exact", int'(exact_cnt), 0);
      checkOutput("exhaust_ninth_win", int'(win), 0);
      checkOutput("exhaust_ninth_attempts", int'(attempts), 8);

      $display("[TB] new_game abort mid-EXACT");
      newGame(1, 2, 3, 4);
      scoreGuess("pre_abort", 4, 3, 2, 1, FULL_LAT, 0, 4, 0, 0, 1);
      applyStimulus(7, 7, 7, 7);
      tick();
      newGame(5, 5, 5, 5);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_attempts", int'(attempts), 0);
      checkOutput("abort_color", int'(color_cnt), 0);
      expectNoDone("abort_no_done", 25);
      scoreGuess("after_abort", 5, 5, 5, 5, WIN_LAT, 4, 0, 1, 1, 1);

      $display("[TB] reset mid-COLOR");
      newGame(1, 2, 3, 4);
      scoreGuess("pre_reset", 1, 3, 2, 4, FULL_LAT, 2, 2, 0, 0, 1);
      applyStimulus(4, 3, 2, 1);
      for (int k = 0; k < 9; k++) tick();
      #3;
      rst = 1'b1;
      #1;
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_exact", int'(exact_cnt), 0);
      checkOutput("rst_color", int'(color_cnt), 0);
      checkOutput("rst_attempts", int'(attempts), 0);
      checkOutput("rst_done", int'(done), 0);
      tick();
      rst = 1'b0;
      expectNoDone("rst_no_done", 25);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/guess_checker.md
Name: guess_checker

Overview:
- Scores a submitted 4-slot colour guess against a latched secret code, Mastermind style.
- Outputs an exact-position count and a right-colour/wrong-position count.
- Sits downstream of the guess-entry block: consumes its four 3-bit slot codes when the player commits a guess.
- Tracks attempts, win and game-over for the top-level game FSM and the display.

Parameters:
- COLOR_W, 3, width of one slot colour code.
- MAX_GUESSES, 8, attempts allowed per game before game_over.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- new_game  in  1  single-cycle pulse: latch secret, clear game state.
- secret_zero..secret_three  in  COLOR_W each  secret slot codes, sampled on new_game.
- start  in  1  single-cycle pulse: commit the current guess.
- guess_zero..guess_three  in  COLOR_W each  guess slot codes, sampled on an accepted start.
- busy  out  1  evaluation in progress.
- done  out  1  one-cycle pulse: result valid.
- exact_cnt  out  3  slots matching in colour and position (0..4).
- color_cnt  out  3  remaining colour matches in the wrong position (0..4).
- win  out  1  last result had exact_cnt==4.
- game_over  out  1  win, or attempts reached MAX_GUESSES.
- attempts  out  $clog2(MAX_GUESSES+1)  scored guesses this game.

Behaviour:
- Reset (async, any state): state=IDLE; secret=0; guess snapshot=0; all outputs 0.
- States: IDLE, EXACT, COLOR, DONE.
- IDLE:
  - start accepted only if !game_over.
  - Accept: snapshot all four guess slots, clear exact/used flags and counters, go to EXACT. busy=1 from the next cycle.
- EXACT: 4 cycles, idx 0..3.
  - If g[idx]==s[idx]: set ex[idx], exact count +1.
- COLOR: 16 cycles, i outer 0..3, j inner 0..3.
  - Match condition: !ex[i] && !gu[i] && !ex[j] && !su[j] && g[i]==s[j].
  - On match: colour count +1, set gu[i] and su[j].
  - This gives correct duplicate-colour handling: each secret slot and each guess slot is counted at most once.
- DONE: 1 cycle.
  - done=1, busy=0.
  - exact_cnt/color_cnt updated; attempts +1.
  - win=(exact==4); game_over=win || attempts_next==MAX_GUESSES.
  - Return to IDLE.
- Latency: start sampled at edge 0 → done high in the cycle after edge 21 (EXACT 4 + COLOR 16 + DONE 1).
- Output holding: exact_cnt, color_cnt and win hold between results; they change only in DONE, on new_game, or on reset.
- start while busy or game_over: ignored, no side effect.
- new_game, any state:
  - Abort any evaluation, go to IDLE.
  - Latch secret; clear attempts, win, game_over, exact_cnt, color_cnt.
  - No done pulse for the aborted evaluation.
- new_game and start in the same cycle: new_game wins, start dropped.
- Guess inputs may change during evaluation; only the snapshot is used.
- Counters are 3-bit and never exceed 4.
- attempts saturates at MAX_GUESSES.

Optional Feature:
- Macro: GUESS_CHECKER_EARLY_EXIT_EN.
- Defined: if exact count==4 at the end of EXACT, skip COLOR and go straight to DONE. Latency becomes 5 (done in the cycle after edge 5), color_cnt=0.
- Undefined: fixed 21-cycle latency for every guess.
- Results are identical in both builds; only latency differs.

Decomposition:
- Shared package:
  - state enum (IDLE/EXACT/COLOR/DONE).
  - SLOTS=4.
  - EXACT_CYCLES=4, COLOR_CYCLES=16.
  - colour code typedef of COLOR_W bits.
- One natural sub-module: guess_attempt_tracker.
  - Owns attempts, win and game_over.
  - Inputs: done, exact_cnt, new_game.
- The evaluation FSM and datapath stay in guess_checker.

Test Plan:
- Exact win: new_game secret 1,2,3,4; start guess 1,2,3,4 → done after 21 cycles (5 with EARLY_EXIT), exact=4, color=0, win=1, game_over=1, attempts=1.
- All misplaced: secret 1,2,3,4; guess 4,3,2,1 → exact=0, color=4, win=0, attempts=1.
- Duplicates: secret 1,1,2,2; guess 1,2,1,5 → exact=1, color=2.
- Exhaustion: 8 losing guesses (guess 7,7,7,7 vs secret 1,2,3,4) → exact=0, color=0 each; attempts=8, game_over=1. A 9th start → no busy, no done, outputs unchanged.
- Start ignored while busy: second start at cycle 3 of an evaluation → exactly one done, attempts +1 only.
- Aborts:
  - rst asserted mid-COLOR → all outputs 0 immediately; no done.
  - new_game mid-EXACT with secret 5,5,5,5 → IDLE, attempts=0; a following guess 5,5,5,5 → exact=4.
